// File: rtl/key_press_detector_if.sv
// Key detector signal bundle: raw button in, debounced events out.
// master drives key_in (button side); slave is the detector.
interface key_press_detector_if;
  logic key_in;
  logic key_flag;
  logic key_state;
  logic key_long;

  modport master (
    output key_in,
    input  key_flag,
    input  key_state,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_flag,
    output key_state,
    output key_long
  );
endinterface

// File: rtl/key_press_detector.sv
// Debounces one raw push-button into press/release and long-press events.
// Ports: Clk, Rst_n (async low); kif.slave: key_in, key_flag, key_state, key_long.
module key_press_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  key_press_detector_if.slave  kif
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LG_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);
  localparam logic [LG_W-1:0] LG_PRE  = LG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILTER_DOWN,
    DOWN,
    FILTER_UP
  } state_t;

  logic s1, s2, s3;
  logic fall, rise;

  state_t          state_q, state_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [LG_W-1:0] lg_q, lg_d;
  logic            ks_q, ks_d;
  logic            flag_q, flag_d;
  logic            long_q, long_d;

  // s1/s2 resolve metastability; s3 is the previous synced level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= kif.key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      db_q    <= '0;
      lg_q    <= '0;
      ks_q    <= 1'b1;
      flag_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      lg_q    <= lg_d;
      ks_q    <= ks_d;
      flag_q  <= flag_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    lg_d    = lg_q;
    ks_d    = ks_q;
    flag_d  = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = FILTER_DOWN;
          db_d    = '0;
        end
      end
      FILTER_DOWN: begin
        // A rise on the terminal cycle still counts as a bounce.
        if (rise) begin
          state_d = IDLE;
        end else if (db_q == DB_LAST) begin
          state_d = DOWN;
          ks_d    = 1'b0;
          flag_d  = 1'b1;
          lg_d    = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      DOWN: begin
        // Saturates at LG_MAX so key_long fires once per press.
        if (lg_q != LG_MAX) begin
          lg_d = lg_q + 1'b1;
          if (lg_q == LG_PRE) begin
            long_d = 1'b1;
          end
        end
        if (rise) begin
          state_d = FILTER_UP;
          db_d    = '0;
        end
      end
      FILTER_UP: begin
        // Long counter held here so a release bounce cannot re-arm it.
        if (fall) begin
          state_d = DOWN;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
          ks_d    = 1'b1;
          flag_d  = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign kif.key_flag  = flag_q;
  assign kif.key_state = ks_q;
  assign kif.key_long  = long_q;

endmodule
